spell_sram_responder: RTL and testbench

- Wishbone classic responder that stands in for the OpenRAM macro on the far side of the memory unit's SRAM port.
- Accepts the memory unit's cyc/stb/we/sel/addr/dat request and performs a 32-bit word access with per-byte write lanes on an internal word array.
- Returns read data and a single-cycle ack after a programmable number of wait states.
- Used in simulation and as the synthesizable fallback SRAM for the spell core.

---
 rtl/spell_sram_responder_if.sv | 47 ++++
 rtl/spell_sram_responder.sv | 190 +++++++++++++++++++
 tb/tb_spell_sram_responder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/spell_sram_responder_if.sv
// ----------------------------------------------------------------------------
// spell_sram_responder_if
//   Wishbone classic request/response bundle between the memory unit
//   (master) and the SRAM responder (slave). Signal names follow the
//   responder's point of view: _i are driven by the master, _o by the slave.
//
//   wb_cyc_i   bus cycle active
//   wb_stb_i   strobe; a request is valid when cyc and stb are both high
//   wb_we_i    1 = write, 0 = read
//   wb_sel_i   byte lane enables, bit i covers data bits [8i+7:8i]
//   wb_addr_i  word address
//   wb_dat_i   write data
//   wb_dat_o   read data, valid with ack and held afterwards
//   wb_ack_o   one-cycle transfer acknowledge
// ----------------------------------------------------------------------------
interface spell_sram_responder_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [7:0]  wb_addr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_cyc_i,
        output wb_stb_i,
        output wb_we_i,
        output wb_sel_i,
        output wb_addr_i,
        output wb_dat_i,
        input  wb_dat_o,
        input  wb_ack_o
    );

    modport slave (
        input  wb_cyc_i,
        input  wb_stb_i,
        input  wb_we_i,
        input  wb_sel_i,
        input  wb_addr_i,
        input  wb_dat_i,
        output wb_dat_o,
        output wb_ack_o
    );
endinterface

// File: rtl/spell_sram_responder.sv
// ----------------------------------------------------------------------------
// spell_sram_responder
//   Wishbone classic responder standing in for the OpenRAM macro behind the
//   memory unit's SRAM port. Performs 32-bit word accesses with per-byte
//   write lanes on an internal word array, acking after WAIT_STATES idle
//   cycles. Also serves as the synthesizable fallback SRAM.
//
//   Ports
//     clock   system clock, rising edge
//     reset   asynchronous, active-low reset
//     bus     Wishbone slave modport (cyc/stb/we/sel/addr/dat in, dat/ack out)
//     busy_o  high while in WAIT or ACK
//     err_o   sticky flag: an out-of-range word address was accessed
//
//   State table
//     state   | meaning
//     --------+-----------------------------------------------------------
//     IDLE    | waiting for cyc && stb; captures the request
//     WAIT    | counting wait states; dropping cyc/stb aborts the access
//     ACK     | ack high for one cycle; always returns to IDLE
// ----------------------------------------------------------------------------
module spell_sram_responder #(
    parameter int WORDS       = 128,
    parameter int WAIT_STATES = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    spell_sram_responder_if.slave        bus,
    output logic                         busy_o,
    output logic                         err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam int         AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [7:0]  addr_q,  addr_d;
    logic        we_q,    we_d;
    logic [3:0]  sel_q,   sel_d;
    logic [31:0] wdat_q,  wdat_d;
    logic [31:0] rdat_q,  rdat_d;
    logic        ack_q,   ack_d;
    logic        busy_q,  busy_d;
    logic        err_q,   err_d;

    logic [31:0] mem [WORDS];

    logic        req;
    logic [7:0]  c_addr;
    logic        c_we;
    logic [3:0]  c_sel;
    logic [31:0] c_dat;
    logic        c_in_range;
    logic [AW-1:0] c_idx;
    logic        commit;

    assign req = bus.wb_cyc_i && bus.wb_stb_i;

    // With zero wait states the commit happens on the capture edge itself,
    // so the live bus request is used; otherwise the captured copy is used.
    always_comb begin
        if (state_q == ST_IDLE) begin
            c_addr = bus.wb_addr_i;
            c_we   = bus.wb_we_i;
            c_sel  = bus.wb_sel_i;
            c_dat  = bus.wb_dat_i;
        end else begin
            c_addr = addr_q;
            c_we   = we_q;
            c_sel  = sel_q;
            c_dat  = wdat_q;
        end
    end

    assign c_in_range = ({1'b0, c_addr} < 9'(WORDS));
    assign c_idx      = c_addr[AW-1:0];

    // Next-state and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d = bus.wb_addr_i;
                    we_d   = bus.wb_we_i;
                    sel_d  = bus.wb_sel_i;
                    wdat_d = bus.wb_dat_i;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_ACK;
                    end else begin
                        cnt_d   = WS;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_ACK;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = 4'(cnt_q - 4'd1);
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        if (commit) begin
            if (!c_we) begin
                rdat_d = c_in_range ? mem[c_idx] : 32'h0000_0000;
            end
            if (!c_in_range) begin
                err_d = 1'b1;
            end
        end

        ack_d  = (state_d == ST_ACK);
        busy_d = (state_d != ST_IDLE);
    end

    // The access commits on the edge that enters ACK. Qualifying with reset
    // keeps an asserted reset from letting a zero-wait-state write slip in.
    assign commit = reset && (state_d == ST_ACK);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 8'd0;
            we_q    <= 1'b0;
            sel_q   <= 4'd0;
            wdat_q  <= 32'd0;
            rdat_q  <= 32'd0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset; contents are undefined until written.
    always_ff @(posedge clock) begin
        if (commit && c_we && c_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (c_sel[i]) begin
                    mem[c_idx][8*i +: 8] <= c_dat[8*i +: 8];
                end
            end
        end
    end

    assign bus.wb_dat_o = rdat_q;
    assign bus.wb_ack_o = ack_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_spell_sram_responder.sv
module tb_spell_sram_responder;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [7:0]  addr = 8'h00;
    logic [31:0] dat = 32'h0;
    int          cur = 0;

    spell_sram_responder_if bus0 ();
    spell_sram_responder_if bus1 ();
    spell_sram_responder_if bus2 ();

    logic busy0, busy1, busy2, err0, err1, err2;

    assign bus0.wb_cyc_i  = cyc && (cur == 0);
    assign bus0.wb_stb_i  = stb && (cur == 0);
    assign bus0.wb_we_i   = we;
    assign bus0.wb_sel_i  = sel;
    assign bus0.wb_addr_i = addr;
    assign bus0.wb_dat_i  = dat;

    assign bus1.wb_cyc_i  = cyc && (cur == 1);
    assign bus1.wb_stb_i  = stb && (cur == 1);
    assign bus1.wb_we_i   = we;
    assign bus1.wb_sel_i  = sel;
    assign bus1.wb_addr_i = addr;
    assign bus1.wb_dat_i  = dat;

    assign bus2.wb_cyc_i  = cyc && (cur == 2);
    assign bus2.wb_stb_i  = stb && (cur == 2);
    assign bus2.wb_we_i   = we;
    assign bus2.wb_sel_i  = sel;
    assign bus2.wb_addr_i = addr;
    assign bus2.wb_dat_i  = dat;

    spell_sram_responder #(.WORDS(128), .WAIT_STATES(1)) u_ws1 (
        .clock(clock), .reset(reset), .bus(bus0), .busy_o(busy0), .err_o(err0));
    spell_sram_responder #(.WORDS(128), .WAIT_STATES(3)) u_ws3 (
        .clock(clock), .reset(reset), .bus(bus1), .busy_o(busy1), .err_o(err1));
    spell_sram_responder #(.WORDS(128), .WAIT_STATES(0)) u_ws0 (
        .clock(clock), .reset(reset), .bus(bus2), .busy_o(busy2), .err_o(err2));

    logic        ack_m, busy_m, err_m;
    logic [31:0] dat_m;

    always_comb begin
        ack_m  = bus2.wb_ack_o;
        dat_m  = bus2.wb_dat_o;
        busy_m = busy2;
        err_m  = err2;
        if (cur == 0) begin
            ack_m = bus0.wb_ack_o; dat_m = bus0.wb_dat_o; busy_m = busy0; err_m = err0;
        end else if (cur == 1) begin
            ack_m = bus1.wb_ack_o; dat_m = bus1.wb_dat_o; busy_m = busy1; err_m = err1;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] dat;
        logic        err;
        int          lat;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] last_rd [3];

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 4 : 1;
    endfunction

    task automatic xfer(input logic w, input logic [3:0] s, input logic [7:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
        sb_t  e;
        int   n;
        logic got;
        @(negedge clock);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; addr = a; dat = d;
        e.we  = w;
        e.dat = w ? last_rd[cur] : exp_rd;
        e.err = exp_err;
        e.lat = lat_of(cur);
        sb_q.push_back(e);
        if (!w) last_rd[cur] = exp_rd;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clock);
            n++;
            got = ack_m;
        end
        cyc = 1'b0; stb = 1'b0;
        e = sb_q.pop_front();
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL ack_timeout: no ack after %0d cycles, expected at %0d", n, e.lat);
        end else begin
            check($sformatf("ack_latency a=%h", a), 32'(n), 32'(e.lat));
            check($sformatf("dat_o a=%h we=%0b", a, w), dat_m, e.dat);
            check($sformatf("err_o a=%h", a), {31'd0, err_m}, {31'd0, e.err});
        end
        @(negedge clock);
        check("ack_single_pulse", {31'd0, ack_m}, 32'd0);
    endtask

    typedef struct {
        int          dut;
        logic        we;
        logic [3:0]  sel;
        logic [7:0]  addr;
        logic [31:0] dat;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt [16];

    initial begin
        logic seen;

        vt[0]  = '{0, 1'b1, 4'hF, 8'h05, 32'hDEADBEEF, 32'h0,        1'b0};
        vt[1]  = '{0, 1'b0, 4'hF, 8'h05, 32'h0,        32'hDEADBEEF, 1'b0};
        vt[2]  = '{0, 1'b1, 4'hF, 8'h03, 32'h11223344, 32'h0,        1'b0};
        vt[3]  = '{0, 1'b1, 4'h4, 8'h03, 32'hAAAAAAAA, 32'h0,        1'b0};
        vt[4]  = '{0, 1'b0, 4'hF, 8'h03, 32'h0,        32'h11AA3344, 1'b0};
        vt[5]  = '{0, 1'b1, 4'h0, 8'h03, 32'hFFFFFFFF, 32'h0,        1'b0};
        vt[6]  = '{0, 1'b0, 4'h0, 8'h03, 32'h0,        32'h11AA3344, 1'b0};
        vt[7]  = '{0, 1'b1, 4'hF, 8'h00, 32'h01020304, 32'h0,        1'b0};
        vt[8]  = '{0, 1'b1, 4'hF, 8'h7F, 32'h55AA55AA, 32'h0,        1'b0};
        vt[9]  = '{0, 1'b0, 4'hF, 8'h7F, 32'h0,        32'h55AA55AA, 1'b0};
        vt[10] = '{0, 1'b0, 4'hF, 8'h90, 32'h0,        32'h00000000, 1'b1};
        vt[11] = '{0, 1'b1, 4'hF, 8'h80, 32'hFFFFFFFF, 32'h0,        1'b1};
        vt[12] = '{0, 1'b0, 4'hF, 8'h00, 32'h0,        32'h01020304, 1'b1};
        vt[13] = '{0, 1'b0, 4'hF, 8'h05, 32'h0,        32'hDEADBEEF, 1'b1};
        vt[14] = '{2, 1'b1, 4'hF, 8'h20, 32'hCAFEF00D, 32'h0,        1'b0};
        vt[15] = '{2, 1'b0, 4'hF, 8'h20, 32'h0,        32'hCAFEF00D, 1'b0};

        for (int i = 0; i < 3; i++) last_rd[i] = 32'h0;

        // Reset state of all three instances.
        repeat (3) @(negedge clock);
        check("rst_ack0",  {31'd0, bus0.wb_ack_o}, 32'd0);
        check("rst_dat0",  bus0.wb_dat_o, 32'd0);
        check("rst_busy0", {31'd0, busy0}, 32'd0);
        check("rst_err0",  {31'd0, err0}, 32'd0);
        check("rst_ack1",  {31'd0, bus1.wb_ack_o}, 32'd0);
        check("rst_busy1", {31'd0, busy1}, 32'd0);
        check("rst_ack2",  {31'd0, bus2.wb_ack_o}, 32'd0);
        check("rst_dat2",  bus2.wb_dat_o, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            cur = vt[i].dut;
            xfer(vt[i].we, vt[i].sel, vt[i].addr, vt[i].dat, vt[i].exp_rd, vt[i].exp_err);
        end

        // Back-to-back with zero wait states and stb held high.
        cur = 2;
        @(negedge clock);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; addr = 8'h10; dat = 32'h01010101;
        @(negedge clock);
        check("b2b_ack_first", {31'd0, ack_m}, 32'd1);
        check("b2b_busy_ack",  {31'd0, busy_m}, 32'd1);
        addr = 8'h11; dat = 32'h02020202;
        @(negedge clock);
        check("b2b_gap_ack",   {31'd0, ack_m}, 32'd0);
        check("b2b_gap_busy",  {31'd0, busy_m}, 32'd0);
        @(negedge clock);
        check("b2b_ack_second", {31'd0, ack_m}, 32'd1);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clock);
        check("b2b_ack_drop", {31'd0, ack_m}, 32'd0);
        xfer(1'b0, 4'hF, 8'h10, 32'h0, 32'h01010101, 1'b0);
        xfer(1'b0, 4'hF, 8'h11, 32'h0, 32'h02020202, 1'b0);

        // Abort during WAIT with three wait states.
        cur = 1;
        xfer(1'b1, 4'hF, 8'h07, 32'h0BADF00D, 32'h0, 1'b0);
        @(negedge clock);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; addr = 8'h07; dat = 32'h12121212;
        @(negedge clock);
        check("abort_busy_wait", {31'd0, busy_m}, 32'd1);
        check("abort_no_early_ack", {31'd0, ack_m}, 32'd0);
        @(negedge clock);
        stb = 1'b0;
        @(negedge clock);
        check("abort_busy_low", {31'd0, busy_m}, 32'd0);
        cyc = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (ack_m) seen = 1'b1;
        end
        check("abort_no_ack", {31'd0, seen}, 32'd0);
        xfer(1'b0, 4'hF, 8'h07, 32'h0, 32'h0BADF00D, 1'b0);

        // Reset asserted mid-write during WAIT.
        xfer(1'b1, 4'hF, 8'h02, 32'h22222222, 32'h0, 1'b0);
        @(negedge clock);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; addr = 8'h02; dat = 32'h99999999;
        @(negedge clock);
        @(negedge clock);
        check("rstmid_busy_before", {31'd0, busy_m}, 32'd1);
        reset = 1'b0;
        #1;
        check("rstmid_ack",  {31'd0, ack_m}, 32'd0);
        check("rstmid_busy", {31'd0, busy_m}, 32'd0);
        check("rstmid_err",  {31'd0, err_m}, 32'd0);
        check("rstmid_err_sticky_cleared", {31'd0, err0}, 32'd0);
        check("rstmid_dat", dat_m, 32'd0);
        @(negedge clock);
        check("rstmid_ack_held", {31'd0, ack_m}, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) last_rd[i] = 32'h0;
        xfer(1'b0, 4'hF, 8'h02, 32'h0, 32'h22222222, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
